// File: rtl/gcd_ctrl.sv
// Control FSM for a 4-bit subtract-and-swap GCD datapath.
// Steers the datapath mux selects and register enables, counts iterations, and runs both handshakes.
module gcd_ctrl #(
    parameter int CNT_W    = 6,
    parameter int MAX_ITER = 31
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_val,
    output logic             req_rdy,
    output logic             resp_val,
    input  logic             resp_rdy,
    input  logic             b_zero,
    input  logic             a_lt,
    output logic [1:0]       a_sel,
    output logic             b_sel,
    output logic             a_en,
    output logic             b_en,
    output logic [CNT_W-1:0] iter_cnt,
    output logic             resp_err,
    output logic             busy
);

    if (MAX_ITER < 1 || MAX_ITER >= (1 << CNT_W)) begin : g_param_check
        $error("gcd_ctrl: MAX_ITER must lie in 1 .. 2**CNT_W-1");
    end

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITER);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        A_FROM_IN  = 2'd0,
        A_FROM_B   = 2'd1,
        A_FROM_SUB = 2'd2
    } a_sel_t;

    typedef struct packed {
        logic   req_rdy;
        logic   resp_val;
        a_sel_t a_sel;
        logic   b_sel;
        logic   a_en;
        logic   b_en;
    } ctl_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             err_nxt;
    ctl_t             ctl;
    ctl_t             ctl_out;
    logic             update_req;
    logic             at_limit;

    assign update_req = a_lt | ~b_zero;
    assign at_limit   = (iter_cnt == MAX_CNT);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; the combinational block below uses blocking ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            iter_cnt <= '0;
            resp_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            iter_cnt <= cnt_nxt;
            resp_err <= err_nxt;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned and infers a latch.
        state_nxt = state;
        cnt_nxt   = iter_cnt;
        err_nxt   = resp_err;
        ctl       = '0;

        unique case (state)
            IDLE: begin
                ctl.req_rdy = 1'b1;
                if (req_val) begin
                    ctl.a_sel = A_FROM_IN;
                    ctl.b_sel = 1'b0;
                    ctl.a_en  = 1'b1;
                    ctl.b_en  = 1'b1;
                    cnt_nxt   = '0;
                    err_nxt   = 1'b0;
                    state_nxt = CALC;
                end
            end

            CALC: begin
                // Abort check outranks the update so iter_cnt can never pass MAX_ITER.
                if (update_req && at_limit) begin
                    err_nxt   = 1'b1;
                    state_nxt = DONE;
                end else if (a_lt) begin
                    ctl.a_sel = A_FROM_B;
                    ctl.b_sel = 1'b1;
                    ctl.a_en  = 1'b1;
                    ctl.b_en  = 1'b1;
                    cnt_nxt   = iter_cnt + 1'b1;
                end else if (!b_zero) begin
                    ctl.a_sel = A_FROM_SUB;
                    ctl.a_en  = 1'b1;
                    cnt_nxt   = iter_cnt + 1'b1;
                end else begin
                    state_nxt = DONE;
                end
            end

            DONE: begin
                ctl.resp_val = 1'b1;
                if (resp_rdy) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Reset forces every control low at once, so a mid-computation reset cannot write the datapath.
    assign ctl_out  = rst_n ? ctl : '0;

    assign req_rdy  = ctl_out.req_rdy;
    assign resp_val = ctl_out.resp_val;
    assign a_sel    = ctl_out.a_sel;
    assign b_sel    = ctl_out.b_sel;
    assign a_en     = ctl_out.a_en;
    assign b_en     = ctl_out.b_en;
    assign busy     = rst_n && (state != IDLE);

    a_iter_bound : assert property (@(posedge clk) disable iff (!rst_n)
        iter_cnt <= MAX_CNT);

    a_sel_legal : assert property (@(posedge clk) disable iff (!rst_n)
        a_sel != 2'd3);

    a_resp_hold : assert property (@(posedge clk) disable iff (!rst_n)
        resp_val && !resp_rdy |=> resp_val && $stable(iter_cnt) && $stable(resp_err));

endmodule

// File: tb/tb_gcd_ctrl.sv
// Self-checking bench for gcd_ctrl: two controllers (MAX_ITER 31 and 8), each driving a 4-bit datapath model.
// Expected results come from a reference GCD algorithm and are checked from a per-controller scoreboard.
module tb_gcd_ctrl;

    localparam int CNT_W = 6;

    typedef struct {
        int    gcd;
        int    iter;
        bit    err;
        string ops;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_val  [2];
    logic             req_rdy  [2];
    logic             resp_val [2];
    logic             resp_rdy [2];
    logic             b_zero   [2];
    logic             a_lt     [2];
    logic [1:0]       a_sel    [2];
    logic             b_sel    [2];
    logic             a_en     [2];
    logic             b_en     [2];
    logic [CNT_W-1:0] iter_cnt [2];
    logic             resp_err [2];
    logic             busy     [2];
    logic [3:0]       in_a     [2];
    logic [3:0]       in_b     [2];
    logic [3:0]       ra       [2];
    logic [3:0]       rb       [2];

    int    n_vec = 0;
    int    n_bad = 0;
    int    cyc = 0;
    int    acc_cyc  [2];
    bit    prev_val [2];
    bit    after_hs [2];
    string ops      [2];
    exp_t  sb0 [$];
    exp_t  sb1 [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gcd_ctrl #(.CNT_W(CNT_W), .MAX_ITER(31)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req_val(req_val[0]), .req_rdy(req_rdy[0]),
        .resp_val(resp_val[0]), .resp_rdy(resp_rdy[0]), .b_zero(b_zero[0]), .a_lt(a_lt[0]),
        .a_sel(a_sel[0]), .b_sel(b_sel[0]), .a_en(a_en[0]), .b_en(b_en[0]),
        .iter_cnt(iter_cnt[0]), .resp_err(resp_err[0]), .busy(busy[0])
    );

    gcd_ctrl #(.CNT_W(CNT_W), .MAX_ITER(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_val(req_val[1]), .req_rdy(req_rdy[1]),
        .resp_val(resp_val[1]), .resp_rdy(resp_rdy[1]), .b_zero(b_zero[1]), .a_lt(a_lt[1]),
        .a_sel(a_sel[1]), .b_sel(b_sel[1]), .a_en(a_en[1]), .b_en(b_en[1]),
        .iter_cnt(iter_cnt[1]), .resp_err(resp_err[1]), .busy(busy[1])
    );

    // Datapath model: A/B registers with no reset, written only through the enables.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (a_en[i]) begin
                case (a_sel[i])
                    2'd0:    ra[i] <= in_a[i];
                    2'd1:    ra[i] <= rb[i];
                    2'd2:    ra[i] <= ra[i] - rb[i];
                    default: ra[i] <= 4'h0;
                endcase
            end
            if (b_en[i]) rb[i] <= b_sel[i] ? ra[i] : in_b[i];
        end
    end

    assign b_zero[0] = (rb[0] == 4'd0);
    assign b_zero[1] = (rb[1] == 4'd0);
    assign a_lt[0]   = (ra[0] < rb[0]);
    assign a_lt[1]   = (ra[1] < rb[1]);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t", tag, got, got, exp, exp, $time);
        end
    endtask

    // Reference algorithm; ops records W=swap, S=subtract, '-'=cycle with no enables.
    function automatic exp_t model(input int a, input int b, input int max_iter);
        exp_t e;
        bit   fin;
        int   t;
        e.iter = 0;
        e.err  = 1'b0;
        e.ops  = "";
        fin    = 1'b0;
        while (!fin) begin
            if ((a < b || b != 0) && e.iter == max_iter) begin
                e.err = 1'b1;
                e.ops = {e.ops, "-"};
                fin   = 1'b1;
            end else if (a < b) begin
                t = a; a = b; b = t;
                e.ops = {e.ops, "W"};
                e.iter++;
            end else if (b != 0) begin
                a = a - b;
                e.ops = {e.ops, "S"};
                e.iter++;
            end else begin
                e.ops = {e.ops, "-"};
                fin   = 1'b1;
            end
        end
        e.gcd = a;
        return e;
    endfunction

    function automatic int sb_size(input int i);
        return (i == 0) ? sb0.size() : sb1.size();
    endfunction

    function automatic exp_t sb_front(input int i);
        return (i == 0) ? sb0[0] : sb1[0];
    endfunction

    function automatic logic [14:0] outs(input int i);
        return {req_rdy[i], resp_val[i], a_sel[i], b_sel[i], a_en[i], b_en[i],
                iter_cnt[i], resp_err[i], busy[i]};
    endfunction

    function automatic string op_char(input int i);
        case ({a_en[i], b_en[i], a_sel[i], b_sel[i]})
            5'b11011: return "W";
            5'b10100: return "S";
            5'b00000: return "-";
            default:  return "X";
        endcase
    endfunction

    task automatic monitor(input int i);
        exp_t e;
        if (!rst_n) begin
            prev_val[i] = 1'b0;
            after_hs[i] = 1'b0;
            return;
        end
        if (after_hs[i]) begin
            check("idle_after_resp", 32'({busy[i], req_rdy[i]}), 32'b01);
            after_hs[i] = 1'b0;
        end
        if (busy[i] && !resp_val[i]) ops[i] = {ops[i], op_char(i)};
        if (resp_val[i]) begin
            check("resp_expected", 32'(sb_size(i) != 0), 32'd1);
            if (sb_size(i) != 0) begin
                e = sb_front(i);
                if (!prev_val[i]) check("latency", 32'(cyc - acc_cyc[i]), 32'(e.iter + 1));
                check("gcd", 32'(ra[i]), 32'(e.gcd));
                check("iter_cnt", 32'(iter_cnt[i]), 32'(e.iter));
                check("resp_err", 32'(resp_err[i]), 32'(e.err));
                check("done_ctl", 32'({req_rdy[i], a_en[i], b_en[i], a_sel[i], b_sel[i], busy[i]}), 32'b0000001);
                if (resp_rdy[i]) begin
                    check("op_sequence", 32'(ops[i] == e.ops), 32'd1);
                    if (ops[i] != e.ops) $display("  dut%0d ops seen %s want %s", i, ops[i], e.ops);
                    if (i == 0) sb0.delete(0); else sb1.delete(0);
                    after_hs[i] = 1'b1;
                end
            end
        end
        prev_val[i] = resp_val[i];
    endtask

    always @(negedge clk) monitor(0);
    always @(negedge clk) monitor(1);

    task automatic send(input int i, input int a, input int b, input bit hold);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        while (!req_rdy[i] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("req_rdy_wait", 32'(req_rdy[i]), 32'd1);
        #1;
        in_a[i]    = 4'(a);
        in_b[i]    = 4'(b);
        req_val[i] = 1'b1;
        ops[i]     = "";
        e = model(a, b, (i == 0) ? 31 : 8);
        if (i == 0) sb0.push_back(e); else sb1.push_back(e);
        @(posedge clk);
        #1;
        acc_cyc[i] = cyc;
        check("accept_state", 32'({busy[i], iter_cnt[i], resp_err[i]}), 32'({1'b1, 6'd0, 1'b0}));
        if (!hold) req_val[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        int n = 0;
        @(negedge clk);
        while (busy[i] && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("done_in_time", 32'(busy[i]), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got t=%0t expected end earlier", $time);
        $fatal(1);
    end

    initial begin
        int n;
        for (int i = 0; i < 2; i++) begin
            req_val[i]  = 1'b0;
            resp_rdy[i] = 1'b1;
            in_a[i]     = 4'd0;
            in_b[i]     = 4'd0;
            acc_cyc[i]  = 0;
            prev_val[i] = 1'b0;
            after_hs[i] = 1'b0;
            ops[i]      = "";
        end
        // Reset with a request pending: all outputs, req_rdy included, must stay low.
        req_val[0] = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_outs0", 32'(outs(0)), 32'd0);
        check("rst_outs1", 32'(outs(1)), 32'd0);
        req_val[0] = 1'b0;
        rst_n = 1'b1;
        #1;
        check("rdy_after_rst0", 32'(req_rdy[0]), 32'd1);
        check("rdy_after_rst1", 32'(req_rdy[1]), 32'd1);

        send(0, 12, 8, 1'b0);  wait_idle(0);
        send(0, 15, 1, 1'b0);  wait_idle(0);
        send(0, 5, 0, 1'b0);   wait_idle(0);
        send(0, 0, 0, 1'b0);   wait_idle(0);
        send(0, 0, 7, 1'b0);   wait_idle(0);
        for (int k = 0; k < 6; k++) begin
            send(0, int'($urandom_range(15, 0)), int'($urandom_range(15, 0)), 1'b0);
            wait_idle(0);
        end

        // Timeout on the MAX_ITER=8 controller, then a clean request clears resp_err.
        send(1, 15, 1, 1'b0);  wait_idle(1);
        send(1, 3, 3, 1'b0);   wait_idle(1);

        // Backpressure: response held 4 cycles while req_val stays asserted.
        @(negedge clk);
        #1 resp_rdy[0] = 1'b0;
        send(0, 9, 6, 1'b1);
        n = 0;
        while (!resp_val[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bp_resp_seen", 32'(resp_val[0]), 32'd1);
        repeat (4) @(negedge clk);
        #1;
        resp_rdy[0] = 1'b1;
        req_val[0]  = 1'b0;
        wait_idle(0);

        // Reset two iterations into 12/8 (after sub then swap: A=8, B=4).
        send(0, 12, 8, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midcalc_rst_outs", 32'(outs(0)), 32'd0);
        @(posedge clk);
        #1;
        check("midcalc_ra_held", 32'(ra[0]), 32'd8);
        check("midcalc_rb_held", 32'(rb[0]), 32'd4);
        sb0.delete();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("post_rst_state", 32'({req_rdy[0], iter_cnt[0], busy[0]}), 32'({1'b1, 6'd0, 1'b0}));

        send(0, 6, 4, 1'b0);   wait_idle(0);

        repeat (2) @(negedge clk);
        check("scoreboard_empty", 32'(sb0.size() + sb1.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/gcd_ctrl.md
Name: gcd_ctrl

Overview:
- Control FSM for the 4-bit subtract-and-swap GCD datapath.
- Accepts an operand request through a valid/ready handshake.
- Each cycle, drives the datapath mux selects and register enables from the datapath status flags (b_zero, a_lt).
- Presents the completion and iteration count through a valid/ready response handshake.
- The datapath result (gcd_o) is read directly from the datapath while resp_val is high.

Parameters:
- CNT_W, 6, width of the iteration counter.
- MAX_ITER, 31, number of update cycles after which the computation aborts with resp_err; must be less than 2^CNT_W.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_val  input  1  operands on datapath a/b inputs are valid.
- req_rdy  output  1  controller can accept operands.
- resp_val  output  1  result on datapath gcd_o is valid.
- resp_rdy  input  1  consumer accepts result.
- b_zero  input  1  datapath status: B register == 0.
- a_lt  input  1  datapath status: A register < B register.
- a_sel  output  2  A mux select: 0 = input a, 1 = B, 2 = A-B, 3 = never driven.
- b_sel  output  1  B mux select: 0 = input b, 1 = A.
- a_en  output  1  A register load enable.
- b_en  output  1  B register load enable.
- iter_cnt  output  CNT_W  number of update cycles in the current or last computation.
- resp_err  output  1  last computation aborted on MAX_ITER; valid with resp_val.
- busy  output  1  high in CALC and DONE.

Behaviour:
- States: IDLE, CALC, DONE. State, iter_cnt and resp_err are registers, asynchronously reset.
- Reset values: state = IDLE, iter_cnt = 0, resp_err = 0.
- While rst_n is low, every output is 0, including req_rdy.
- Controls are combinational from the current state and the status inputs. Outputs not listed in a state are 0. a_sel and b_sel are 0 whenever the matching enable is 0.
- IDLE:
  - req_rdy = 1.
  - If req_val: a_sel = 0, b_sel = 0, a_en = 1, b_en = 1 (load operands), iter_cnt <= 0, resp_err <= 0, go to CALC.
  - Otherwise remain in IDLE.
- CALC, evaluated in strict priority order:
  - (1) Update required (a_lt = 1, or b_zero = 0) and iter_cnt == MAX_ITER: no enables, resp_err <= 1, go to DONE.
  - (2) a_lt = 1: swap. a_sel = 1, b_sel = 1, a_en = 1, b_en = 1; A and B exchange on the same edge. iter_cnt <= iter_cnt + 1.
  - (3) b_zero = 0: subtract. a_sel = 2, a_en = 1, b_en = 0. iter_cnt <= iter_cnt + 1.
  - (4) Otherwise (B == 0 and not a_lt): no enables, go to DONE.
- DONE:
  - resp_val = 1, all enables 0, req_rdy = 0, req_val ignored.
  - On resp_rdy, go to IDLE.
  - resp_val and resp_err hold stable until the response handshake.
- busy = (state != IDLE).
- Latency: the request handshake edge loads operands. Each following CALC cycle with an enable is one iteration. One extra CALC cycle detects termination. resp_val rises N+1 edges after the accept edge, where N = iter_cnt.
- A new request is accepted no earlier than the cycle after the resp handshake (no same-cycle response/request overlap).
- iter_cnt never wraps; MAX_ITER bounds it.
- Operands a = 0, b = 0 terminate immediately with gcd 0. a_lt = 1 with b_zero = 1 cannot occur; if it does, the swap takes priority.
- Reset asserted mid-CALC or mid-DONE aborts immediately: the datapath registers are not written and the pending response is lost.

Test Plan:
- a = 12, b = 8, resp_rdy = 1 → sequence sub, swap, sub, sub, swap; iter_cnt = 5; resp_val rises 6 edges after accept; gcd_o = 4; resp_err = 0.
- a = 15, b = 1 → 15 subtracts + 1 swap; iter_cnt = 16; gcd_o = 1; resp_err = 0. a = 5, b = 0 → iter_cnt = 0, gcd_o = 5, resp_val 1 edge after accept.
- a = 0, b = 0 → DONE after a single CALC cycle; iter_cnt = 0; gcd_o = 0; no enables asserted in CALC.
- Backpressure: a = 9, b = 6 with resp_rdy held low 4 cycles while req_val stays high → resp_val, gcd_o = 3 and iter_cnt stable; req_rdy = 0; all enables 0; IDLE reached the cycle after resp_rdy rises.
- Timeout: MAX_ITER = 8, a = 15, b = 1 → resp_err = 1, iter_cnt = 8, gcd_o = 7; next request clears resp_err on accept.
- Reset mid-CALC (a = 12, b = 8, rst_n low after 2 iterations) → all outputs 0 immediately; after release req_rdy = 1, iter_cnt = 0, busy = 0.
